// File: rtl/cu_pkg.sv
// Shared types and constants for the control unit: opcodes, FSM states, ALU selects, IR fields.
// CONTROL_UNIT_STEP_EN adds the single-step PAUSE state to the state enum.
package cu_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'b0000,
        OP_STORE = 4'b0001,
        OP_LOAD  = 4'b0010,
        OP_ADD   = 4'b0011,
        OP_SUB   = 4'b0100,
        OP_HALT  = 4'b0101
    } opcode_t;

    // Enum values double as the State_Out encoding.
    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
`ifdef CONTROL_UNIT_STEP_EN
        ,
        S_PAUSE  = 4'd10
`endif
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RA_HI = 11;
    localparam int RA_LO = 8;
    localparam int RB_HI = 7;
    localparam int RB_LO = 4;
    localparam int RD_HI = 3;
    localparam int RD_LO = 0;

endpackage

// File: rtl/cu_decode.sv
// Opcode to execute-state decoder; purely combinational.
// Unknown opcodes fall back to the NOOP execute state.
module cu_decode
    import cu_pkg::*;
(
    input  logic [3:0] opcode,
    output state_t     exec_state
);

    always_comb begin
        exec_state = S_NOOP;
        case (opcode)
            OP_STORE: exec_state = S_STORE;
            OP_LOAD:  exec_state = S_LOAD_A;
            OP_ADD:   exec_state = S_ADD;
            OP_SUB:   exec_state = S_SUB;
            OP_HALT:  exec_state = S_HALT;
            default:  exec_state = S_NOOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: PC, IR and FSM driving a register-file/ALU/data-memory datapath.
// CONTROL_UNIT_STEP_EN adds a Step input and a PAUSE state after every execute state.
module control_unit
    import cu_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            reset,
`ifdef CONTROL_UNIT_STEP_EN
    input  logic            Step,
`endif
    input  logic [15:0]     I_Data,
    output logic [PC_W-1:0] PC_Out,
    output logic [15:0]     IR_Out,
    output logic [3:0]      State_Out,
    output logic            Halted,
    output logic [3:0]      D_Addr,
    output logic            D_WriteEn,
    output logic            MuxS,
    output logic [3:0]      RegF_W_addr,
    output logic            RegF_W_en,
    output logic [3:0]      RegF_Ra_addr,
    output logic [3:0]      RegF_Rb_addr,
    output logic [2:0]      ALU_S
);

`ifdef CONTROL_UNIT_STEP_EN
    localparam state_t EXEC_DONE = S_PAUSE;
`else
    localparam state_t EXEC_DONE = S_FETCH;
`endif

    state_t          state;
    state_t          state_nxt;
    state_t          exec_state;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;

    cu_decode u_decode (
        .opcode     (I_Data[OP_HI:OP_LO]),
        .exec_state (exec_state)
    );

    // I_Data is only meaningful in DECODE: the ROM saw PC during FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_INIT;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH)
                pc <= pc + 1'b1;
            if (state == S_DECODE)
                ir <= I_Data;
        end
    end

    // Outputs decode from state alone so an async reset clears them immediately.
    always_comb begin
        state_nxt = state;
        D_WriteEn = 1'b0;
        RegF_W_en = 1'b0;
        MuxS      = 1'b0;
        ALU_S     = ALU_PASS;
        Halted    = 1'b0;
        case (state)
            S_INIT:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = exec_state;
            S_NOOP:   state_nxt = EXEC_DONE;
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_LOAD_B: begin
                MuxS      = 1'b1;
                RegF_W_en = 1'b1;
                state_nxt = EXEC_DONE;
            end
            S_STORE: begin
                D_WriteEn = 1'b1;
                state_nxt = EXEC_DONE;
            end
            S_ADD: begin
                ALU_S     = ALU_ADD;
                RegF_W_en = 1'b1;
                state_nxt = EXEC_DONE;
            end
            S_SUB: begin
                ALU_S     = ALU_SUB;
                RegF_W_en = 1'b1;
                state_nxt = EXEC_DONE;
            end
            S_HALT: begin
                Halted    = 1'b1;
                state_nxt = S_HALT;
            end
`ifdef CONTROL_UNIT_STEP_EN
            S_PAUSE: begin
                if (Step)
                    state_nxt = S_FETCH;
            end
`endif
            default:  state_nxt = S_INIT;
        endcase
    end

    assign PC_Out       = pc;
    assign IR_Out       = ir;
    assign State_Out    = state;
    assign RegF_Ra_addr = ir[RA_HI:RA_LO];
    assign RegF_Rb_addr = ir[RB_HI:RB_LO];
    assign D_Addr       = ir[RB_HI:RB_LO];
    assign RegF_W_addr  = ir[RD_HI:RD_LO];

endmodule
